// File: rtl/seq_multiplier_nxn.sv
// seq_multiplier_nxn: iterative WIDTHxWIDTH multiplier, DIGIT multiplier bits per cycle, signed/unsigned.
// Define SEG_STATE_EN to add a registered seven-segment display of the FSM state.
module seq_multiplier_nxn #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic               busy,
  output logic               done_flag,
  output logic [2*WIDTH-1:0] product
`ifdef SEG_STATE_EN
  ,
  output logic               seg_a,
  output logic               seg_b,
  output logic               seg_c,
  output logic               seg_d,
  output logic               seg_e,
  output logic               seg_f,
  output logic               seg_g
`endif
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] sh_a, acc, part;
  logic [WIDTH-1:0]   sh_b, mag_a, mag_b;
  logic [CW-1:0]      count;
  logic               neg, last;
  assign mag_a = (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
  assign mag_b = (signed_mode && datab[WIDTH-1]) ? -datab : datab;
  // multiplicand pre-shifted and multiplier consumed from the bottom, so each digit's weight is implicit
  assign part  = sh_a * {{(2*WIDTH-DIGIT){1'b0}}, sh_b[DIGIT-1:0]};
  assign last  = state == CALC && count == CW'(N);
  assign busy  = state != IDLE;
  always_comb
    state_nxt = state == IDLE ? (start ? CALC : IDLE) :
                state == CALC ? (last ? DONE : CALC) : IDLE;
  always_ff @(posedge clk)
    state <= !reset_a ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (!reset_a) begin
      sh_a      <= '0;
      sh_b      <= '0;
      acc       <= '0;
      count     <= '0;
      neg       <= 1'b0;
      product   <= '0;
      done_flag <= 1'b0;
    end else begin
      done_flag <= last;
      if (state == IDLE && start) begin
        sh_a  <= {{WIDTH{1'b0}}, mag_a};
        sh_b  <= mag_b;
        neg   <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
        acc   <= '0;
        count <= '0;
      end
      if (state == CALC && !last) begin
        acc   <= acc + part;
        sh_a  <= sh_a << DIGIT;
        sh_b  <= sh_b >> DIGIT;
        count <= count + CW'(1);
      end
      if (last)
        product <= neg ? -acc : acc;
    end
  end
`ifdef SEG_STATE_EN
  logic [6:0] seg;
  always_ff @(posedge clk)
    seg <= !reset_a             ? 7'b1111110 :
           state_nxt == CALC    ? 7'b0110000 :
           state_nxt == DONE    ? 7'b1101101 : 7'b1111110;
  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
`endif
endmodule

// File: tb/tb_seq_multiplier_nxn.sv
// tb_seq_multiplier_nxn: randomized scoreboard bench for seq_multiplier_nxn against an arithmetic reference.
module tb_seq_multiplier_nxn;
  parameter int W = 8;
  parameter int D = 2;
  localparam int N = W / D;
  logic           clk = 1'b0;
  logic           reset_a = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   dataa = '0;
  logic [W-1:0]   datab = '0;
  logic           busy, done_flag;
  logic [2*W-1:0] product;
  int             n_chk = 0;
  int             n_fail = 0;
  int             cyc = 0;
  logic           rst_seen = 1'b0;
  logic [2*W-1:0] hold = '0;
  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];
`ifdef SEG_STATE_EN
  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
`endif

  seq_multiplier_nxn #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .reset_a(reset_a), .start(start), .signed_mode(signed_mode),
    .dataa(dataa), .datab(datab), .busy(busy), .done_flag(done_flag), .product(product)
`ifdef SEG_STATE_EN
    , .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= !reset_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(x * y);
  endfunction

  // called at the negedge before the accepting edge
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_q.push_back(ref_mul(a, b, s));
    cyc_q.push_back(cyc + N + 2);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      check("idle_timeout", 64'(busy), 64'(0));
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic keep);
    wait_idle();
    dataa = a;
    datab = b;
    signed_mode = s;
    start = 1'b1;
    push_exp(a, b, s);
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
    if (!keep) start = 1'b0;
  endtask

  // monitor: pops the scoreboard on every done_flag, otherwise product must hold
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int c;
    if (rst_seen) begin
      exp_q.delete();
      cyc_q.delete();
      hold = '0;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done_flag), 64'(0));
      check("rst_product", 64'(product), 64'(0));
    end else if (done_flag) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done_flag=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("product", 64'(product), 64'(e));
        check("latency", 64'(cyc), 64'(c));
        check("busy_in_done", 64'(busy), 64'(1));
        hold = e;
      end
    end else begin
      check("product_hold", 64'(product), 64'(hold));
    end
`ifdef SEG_STATE_EN
    check("seg", 64'({seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}),
          rst_seen || !busy ? 64'h7E : done_flag ? 64'h6D : 64'h30);
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic s;
    int busy_cnt;
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    launch(W'(7), W'(3), 1'b0, 1'b0);
    busy_cnt = 1;
    while (busy && busy_cnt < 50) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    check("busy_cycles", 64'(busy_cnt), 64'(N + 2));
    launch(W'(50), W'(10), 1'b0, 1'b0);
    launch(W'(255), W'(255), 1'b0, 1'b0);
    launch({W{1'b1}}, {W{1'b1}}, 1'b0, 1'b0);
    launch(W'(-3), W'(5), 1'b1, 1'b0);
    launch({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b1, 1'b0);
    launch('0, {1'b1, {(W-1){1'b0}}}, 1'b1, 1'b0);
    launch(W'(-7), W'(-9), 1'b1, 1'b0);
    // start held with new operands while busy: ignored, then relaunches once idle
    launch(W'(10), W'(5), 1'b0, 1'b1);
    dataa = W'(9);
    datab = W'(9);
    wait_idle();
    push_exp(W'(9), W'(9), 1'b0);
    @(negedge clk);
    start = 1'b0;
    // reset on the second CALC edge aborts the operation
    launch(W'(7), W'(3), 1'b0, 1'b0);
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b1;
    repeat (N + 3) @(negedge clk);
    launch(W'(10), W'(5), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom_range(0, 1));
      launch(a, b, s, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        dataa = W'($urandom);
        datab = W'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
